alu_multicycle: RTL and testbench
=================================

// Module: alu_multicycle
// PURPOSE
//   Execute-stage ALU driven by the 4-bit ALU control code from the ALU control decoder.
//   Single-cycle ops (AND/OR/ADD/SUB/SLT) complete in one clock.
//   MULT runs an iterative shift-add multiplier over DATA_W clocks; busy_o stalls the pipeline meanwhile.
//   Registered result, zero flag and a one-cycle valid_o strobe go to the MEM/WB path.
// PARAMETERS
//   DATA_W   32   operand/result width; also the MULT iteration count
// PORTS
//   clk_i     in   1        clock; all state updates on rising edge
//   rst_i     in   1        asynchronous, active-low reset
//   start_i   in   1        issue strobe; sampled only when busy_o==0
//   ctrl_i    in   4        ALU control code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1000 MULT
//   src1_i    in   DATA_W   operand A; captured at issue
//   src2_i    in   DATA_W   operand B; captured at issue
//   result_o  out  DATA_W   registered result; holds until the next completion
//   zero_o    out  1        registered (result_o == 0); updates with result_o
//   valid_o   out  1        one-cycle pulse: result_o/zero_o were updated this cycle
//   busy_o    out  1        high while a MULT is iterating; upstream must hold issue
// BEHAVIOUR
//   Reset (rst_i==0, any time, asynchronous):
//   - state=IDLE; result_o=0, zero_o=1, valid_o=0, busy_o=0.
//   - Internal operand, accumulator and counter registers cleared.
//   - A MULT in flight is aborted and produces no valid_o.
//   States:
//   - IDLE: on an edge with start_i=1:
//     - ctrl_i != 1000: result computed and registered at that edge; valid_o=1 for the next cycle. Latency 1.
//     - ctrl_i == 1000: src1_i/src2_i captured, accumulator=0, counter=DATA_W-1, go to MUL, busy_o=1 next cycle.
//   - MUL: each edge, if multiplier LSB=1 add multiplicand to accumulator; shift multiplicand left, multiplier right.
//     - On the edge where counter==0: accumulator written to result_o, valid_o=1, busy_o=0, return to IDLE.
//     - counter decrements otherwise.
//     - Issue edge E0 -> valid_o high after edge E_DATA_W: 32 clocks at default.
//   - start_i is ignored while busy_o==1; ctrl_i/src changes during MUL have no effect.
//   - Back-to-back: start_i is accepted in the same cycle valid_o is high, since busy_o==0 there.
//   Arithmetic:
//   - ADD/SUB wrap modulo 2^DATA_W; no overflow flag.
//   - SLT is signed two's-complement compare; result 1 or 0, zero-extended.
//   - MULT returns the low DATA_W bits of the product, identical for signed and unsigned.
//   - Undefined ctrl_i code: result_o=0, zero_o=1, valid_o still pulses with latency 1.
//   valid_o is never high for two consecutive cycles from the same issue.
//   start_i=0 in IDLE: outputs hold, valid_o=0.
// TESTING
//   1. Reset release, no start -> result_o=0, zero_o=1, valid_o=0, busy_o=0 held for 10 cycles.
//   2. ADD 0x7FFFFFFF+1 -> 0x80000000 after 1 cycle; SUB 5-5 -> 0, zero_o=1; AND 0xF0F0&0xFF00 -> 0xF000; OR 0x0F|0xF0 -> 0xFF.
//   3. SLT: 0xFFFFFFFF (-1) vs 1 -> 1; 1 vs 0xFFFFFFFF -> 0; each with valid_o high exactly one cycle.
//   4. MULT 7*6 -> busy_o high 32 cycles, then result_o=42, valid_o pulse.
//      MULT 0xFFFFFFFF*0xFFFFFFFF -> 1.
//      start_i pulsed and operands toggled mid-MUL -> result unchanged.
//   5. Reset asserted at MUL cycle 10 -> outputs at reset values immediately; no valid_o after release; next ADD 2+3 -> 5.
//   6. MULT 3*3 then ADD 1+1 issued in the valid_o cycle -> 9 then 2 on consecutive valid_o pulses.
//      Undefined code 1111 -> result_o=0, valid_o pulses.

Source files
------------

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops plus an iterative
// shift-add multiplier that holds busy_o while it runs.
module alu_multicycle #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [3:0]        ctrl_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              valid_o,
    output logic              busy_o
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MUL  = 1'b1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULT = 4'b1000;

    logic [0:0]        state;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] acc;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] acc_next;

    always_comb begin
        alu_out = '0;
        case (ctrl_i)
            OP_AND:  alu_out = src1_i & src2_i;
            OP_OR:   alu_out = src1_i | src2_i;
            OP_ADD:  alu_out = src1_i + src2_i;
            OP_SUB:  alu_out = src1_i - src2_i;
            OP_SLT:  alu_out = {{(DATA_W-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            default: alu_out = '0;
        endcase
    end

    // The final iteration's partial product goes straight to result_o,
    // so the accumulator never needs a separate write-back cycle.
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign busy_o   = (state == MUL);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            count    <= '0;
            result_o <= '0;
            zero_o   <= 1'b1;
            valid_o  <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (ctrl_i == OP_MULT) begin
                            mcand  <= src1_i;
                            mplier <= src2_i;
                            acc    <= '0;
                            count  <= CNT_W'(DATA_W - 1);
                            state  <= MUL;
                        end else begin
                            result_o <= alu_out;
                            zero_o   <= (alu_out == '0);
                            valid_o  <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    if (count == '0) begin
                        result_o <= acc_next;
                        zero_o   <= (acc_next == '0);
                        valid_o  <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        acc    <= acc_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        count  <= count - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: a cycle-level behavioural model
// compared every cycle, plus directed literal checks and random traffic.
module tb_alu_multicycle;

    localparam int DATA_W = 32;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              start_i = 1'b0;
    logic [3:0]        ctrl_i = 4'b0000;
    logic [DATA_W-1:0] src1_i = '0;
    logic [DATA_W-1:0] src2_i = '0;
    logic [DATA_W-1:0] result_o;
    logic              zero_o;
    logic              valid_o;
    logic              busy_o;

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;

    alu_multicycle #(.DATA_W(DATA_W)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .ctrl_i   (ctrl_i),
        .src1_i   (src1_i),
        .src2_i   (src2_i),
        .result_o (result_o),
        .zero_o   (zero_o),
        .valid_o  (valid_o),
        .busy_o   (busy_o)
    );

    initial forever #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks what the outputs must be, cycle by cycle.
    logic [DATA_W-1:0] exp_result = '0;
    logic              exp_zero   = 1'b1;
    logic              exp_valid  = 1'b0;
    int                remaining  = 0;
    logic [DATA_W-1:0] pending    = '0;

    function automatic logic [DATA_W-1:0] ref_alu(input logic [3:0] c, input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return '0;
        endcase
    endfunction

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            exp_result = '0;
            exp_zero   = 1'b1;
            exp_valid  = 1'b0;
            remaining  = 0;
            pending    = '0;
        end else begin
            exp_valid = 1'b0;
            if (remaining > 0) begin
                remaining--;
                if (remaining == 0) begin
                    exp_result = pending;
                    exp_zero   = (pending == '0);
                    exp_valid  = 1'b1;
                end
            end else if (start_i) begin
                if (ctrl_i == 4'b1000) begin
                    logic [63:0] p;
                    p = 64'(src1_i) * 64'(src2_i);
                    pending   = p[DATA_W-1:0];
                    remaining = DATA_W;
                end else begin
                    exp_result = ref_alu(ctrl_i, src1_i, src2_i);
                    exp_zero   = (exp_result == '0);
                    exp_valid  = 1'b1;
                end
            end
        end
    end

    always @(negedge clk_i) begin
        if (checking) begin
            check("cyc_result", result_o, exp_result);
            check("cyc_zero", 32'(zero_o), 32'(exp_zero));
            check("cyc_valid", 32'(valid_o), 32'(exp_valid));
            check("cyc_busy", 32'(busy_o), 32'(remaining > 0));
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [3:0] c, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        start_i = 1'b1;
        ctrl_i  = c;
        src1_i  = a;
        src2_i  = b;
        step();
        start_i = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (busy_o && n < 200) begin
            n++;
            step();
        end
        check("mul_timeout", 32'(busy_o), 32'd0);
    endtask

    logic [3:0] codes [0:7];
    int n;
    int vcount;

    initial begin
        codes[0] = 4'b0000; codes[1] = 4'b0001; codes[2] = 4'b0010; codes[3] = 4'b0110;
        codes[4] = 4'b0111; codes[5] = 4'b1000; codes[6] = 4'b0010; codes[7] = 4'b1111;

        #1 rst_i = 1'b0;
        #1 checking = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_result", result_o, 32'h0);
            check("idle_zero", 32'(zero_o), 32'd1);
            check("idle_valid", 32'(valid_o), 32'd0);
            check("idle_busy", 32'(busy_o), 32'd0);
        end

        issue(4'b0010, 32'h7FFFFFFF, 32'h1);
        check("add_wrap", result_o, 32'h80000000);
        check("add_valid", 32'(valid_o), 32'd1);
        issue(4'b0110, 32'd5, 32'd5);
        check("sub_zero_res", result_o, 32'h0);
        check("sub_zero_flag", 32'(zero_o), 32'd1);
        issue(4'b0000, 32'hF0F0, 32'hFF00);
        check("and", result_o, 32'hF000);
        check("and_zero", 32'(zero_o), 32'd0);
        issue(4'b0001, 32'h0F, 32'hF0);
        check("or", result_o, 32'hFF);

        issue(4'b0111, 32'hFFFFFFFF, 32'd1);
        check("slt_neg", result_o, 32'd1);
        check("slt_neg_valid", 32'(valid_o), 32'd1);
        step();
        check("slt_neg_once", 32'(valid_o), 32'd0);
        issue(4'b0111, 32'd1, 32'hFFFFFFFF);
        check("slt_pos", result_o, 32'd0);
        check("slt_pos_valid", 32'(valid_o), 32'd1);
        step();
        check("slt_pos_once", 32'(valid_o), 32'd0);

        issue(4'b1000, 32'd7, 32'd6);
        wait_done(n);
        check("mul_busy_cycles", 32'(n), 32'd32);
        check("mul_7x6", result_o, 32'd42);
        check("mul_valid", 32'(valid_o), 32'd1);
        step();
        check("mul_valid_once", 32'(valid_o), 32'd0);

        issue(4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(n);
        check("mul_ones", result_o, 32'd1);

        // Upstream misbehaves mid-multiply; the captured operands must win.
        issue(4'b1000, 32'd123, 32'd456);
        for (int i = 0; i < 10; i++) begin
            start_i = i[0];
            ctrl_i  = 4'b0010;
            src1_i  = $urandom;
            src2_i  = $urandom;
            step();
        end
        start_i = 1'b0;
        wait_done(n);
        check("mul_hold_ops", result_o, 32'd56088);

        issue(4'b1000, 32'd1000, 32'd1000);
        repeat (10) step();
        #2 rst_i = 1'b0;
        #1;
        check("rst_result", result_o, 32'h0);
        check("rst_zero", 32'(zero_o), 32'd1);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        step();
        step();
        rst_i = 1'b1;
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (valid_o) vcount++;
        end
        check("rst_no_valid", 32'(vcount), 32'd0);
        issue(4'b0010, 32'd2, 32'd3);
        check("post_rst_add", result_o, 32'd5);

        issue(4'b1000, 32'd3, 32'd3);
        wait_done(n);
        check("b2b_mul", result_o, 32'd9);
        check("b2b_mul_valid", 32'(valid_o), 32'd1);
        issue(4'b0010, 32'd1, 32'd1);
        check("b2b_add", result_o, 32'd2);
        check("b2b_add_valid", 32'(valid_o), 32'd1);

        issue(4'b1111, 32'd9, 32'd9);
        check("undef_res", result_o, 32'h0);
        check("undef_zero", 32'(zero_o), 32'd1);
        check("undef_valid", 32'(valid_o), 32'd1);

        for (int i = 0; i < 400; i++) begin
            start_i = ($urandom_range(0, 3) != 0);
            ctrl_i  = codes[$urandom_range(0, 7)];
            if (ctrl_i == 4'b1000 && $urandom_range(0, 3) != 0) ctrl_i = 4'b0110;
            src1_i  = $urandom;
            src2_i  = ($urandom_range(0, 7) == 0) ? src1_i : $urandom;
            step();
        end
        start_i = 1'b0;
        repeat (40) step();

        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
